// File: rtl/bch_ibm_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bch_ibm_iter
//  Purpose  : Iterative inversionless Berlekamp-Massey solver for binary BCH
//             decoding over GF(2^M). It takes 2T syndromes and produces the
//             error-locator polynomial, one iteration per clock.
//  Config   : BCH_IBM_BINARY_EN defined   -> binary-BCH simplification,
//                                            even steps only (T iterations)
//             BCH_IBM_BINARY_EN undefined -> full 2T-step iBM
//  Ports    : clk     in   clock, rising-edge
//             rst     in   asynchronous reset, active low
//             start   in   one-cycle request, sampled in IDLE only
//             S       in   2T*M syndromes, S[j*M +: M] = S_(j+1)
//             busy    out  high while a run is in progress
//             done    out  one-cycle pulse, results valid from that cycle
//             lambda  out  (T+1)*M locator coefficients, lambda[i*M +: M] = l_i
//             deg     out  final register L
//             fail    out  uncorrectable (L > T)
//  Revision : 1.0  initial release
// ============================================================================
module bch_ibm_iter #(
    parameter  int           M    = 4,
    parameter  int           T    = 2,
    parameter  logic [M:0]   POLY = 5'b10011,
    localparam int           LW   = $clog2(2*T+1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*T*M-1:0]     S,
    output logic                 busy,
    output logic                 done,
    output logic [(T+1)*M-1:0]   lambda,
    output logic [LW-1:0]        deg,
    output logic                 fail
);

`ifdef BCH_IBM_BINARY_EN
    localparam int STEP_INC  = 2;
    localparam int LAST_STEP = 2*T - 2;
`else
    localparam int STEP_INC  = 1;
    localparam int LAST_STEP = 2*T - 1;
`endif

    localparam logic [M-1:0] GF_ONE = M'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [M-1:0]    syn     [0:2*T-1];
    logic [M-1:0]    lam     [0:T];
    logic [M-1:0]    bb      [0:T];
    logic [M-1:0]    gam;
    logic [LW-1:0]   len;
    logic [LW-1:0]   step;

    logic [M-1:0]    delta;
    logic [M-1:0]    lam_nxt [0:T];
    logic [M-1:0]    bb_nxt  [0:T];
    logic            upd;
    logic [LW-1:0]   len_nxt;

    // Shift-and-add multiply; the running multiplicand is reduced by POLY
    // every time it is shifted, so no wide intermediate product is needed.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int n = 0; n < M; n++) begin
            if (b[n]) acc = acc ^ sh;
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY[M-1:0] : '0);
        end
        return acc;
    endfunction

    // Discrepancy: sum of l_i * S_(r+1-i); syn[k] holds S_(k+1), so the term
    // pairs with syndrome index k exactly when r == i + k.
    always_comb begin
        delta = '0;
        for (int i = 0; i <= T; i++) begin
            for (int k = 0; k < 2*T; k++) begin
                if (int'(step) == i + k) delta = delta ^ gf_mul(lam[i], syn[k]);
            end
        end
    end

    always_comb begin
        upd     = (delta != '0) && (2 * int'(len) <= int'(step));
        len_nxt = LW'(int'(step) + 1 - int'(len));

        // lambda <- gamma*lambda + delta*x*B, truncated at degree T
        for (int i = 0; i <= T; i++) begin
            lam_nxt[i] = gf_mul(gam, lam[i]);
        end
        for (int i = 1; i <= T; i++) begin
            lam_nxt[i] = lam_nxt[i] ^ gf_mul(delta, bb[i-1]);
        end

        for (int i = 0; i <= T; i++) begin
            bb_nxt[i] = '0;
        end
`ifdef BCH_IBM_BINARY_EN
        // Odd steps always have zero discrepancy for binary codes, so they
        // collapse into an extra shift of B.
        if (upd) begin
            for (int i = 1; i <= T; i++) bb_nxt[i] = lam[i-1];
        end else begin
            for (int i = 2; i <= T; i++) bb_nxt[i] = bb[i-2];
        end
`else
        if (upd) begin
            for (int i = 0; i <= T; i++) bb_nxt[i] = lam[i];
        end else begin
            for (int i = 1; i <= T; i++) bb_nxt[i] = bb[i-1];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            lambda <= '0;
            deg    <= '0;
            fail   <= 1'b0;
            gam    <= '0;
            len    <= '0;
            step   <= '0;
            for (int k = 0; k < 2*T; k++) syn[k] <= '0;
            for (int i = 0; i <= T; i++) begin
                lam[i] <= '0;
                bb[i]  <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 2*T; k++) syn[k] <= S[k*M +: M];
                        for (int i = 0; i <= T; i++) begin
                            lam[i] <= (i == 0) ? GF_ONE : '0;
                            bb[i]  <= (i == 0) ? GF_ONE : '0;
                        end
                        gam   <= GF_ONE;
                        len   <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    for (int i = 0; i <= T; i++) begin
                        lam[i] <= lam_nxt[i];
                        bb[i]  <= bb_nxt[i];
                    end
                    if (upd) begin
                        len <= len_nxt;
                        gam <= delta;
                    end
                    if (step == LW'(LAST_STEP)) begin
                        state <= ST_DONE;
                    end else begin
                        step <= step + LW'(STEP_INC);
                    end
                end
                ST_DONE: begin
                    for (int i = 0; i <= T; i++) lambda[i*M +: M] <= lam[i];
                    deg   <= len;
                    fail  <= (len > LW'(T));
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
